// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode trap/MRET CSR sequencer.
package csr_pkg;

    localparam int XLEN = 32;

    // CSR addresses used by the trap sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mtvec mode encoding for vectored interrupts
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // cause code reported for the external interrupt line
    localparam logic [4:0] CAUSE_EXT_IRQ = 5'd11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_EPC   = 3'd1,
        T_CAUSE = 3'd2,
        T_STAT  = 3'd3,
        T_VEC   = 3'd4,
        M_STAT  = 3'd5,
        M_EPC   = 3'd6
    } trap_state_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// Owns the reg_file CSR ports during trap entry and MRET; otherwise forwards
// the pipeline's CSR accesses untouched and redirects fetch when done.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int          XLEN_P       = XLEN,
    parameter logic [11:0] ADDR_MSTATUS = CSR_MSTATUS,
    parameter logic [11:0] ADDR_MTVEC   = CSR_MTVEC,
    parameter logic [11:0] ADDR_MEPC    = CSR_MEPC,
    parameter logic [11:0] ADDR_MCAUSE  = CSR_MCAUSE,
    parameter logic [4:0]  IRQ_CAUSE    = CAUSE_EXT_IRQ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exc_valid_pi,
    input  logic [4:0]        exc_cause_pi,
    input  logic              irq_pi,
    input  logic              mret_pi,
    input  logic [XLEN_P-1:0] trap_pc_pi,
    input  logic              pipe_csr_we_pi,
    input  logic [11:0]       pipe_csr_waddr_pi,
    input  logic [XLEN_P-1:0] pipe_csr_wdata_pi,
    input  logic [11:0]       pipe_csr_raddr_pi,
    output logic [XLEN_P-1:0] pipe_csr_rdata_po,
    output logic              write_csr_po,
    output logic [11:0]       csr_waddr_po,
    output logic [XLEN_P-1:0] csr_wdata_po,
    output logic [11:0]       csr_raddr_po,
    input  logic [XLEN_P-1:0] csr_rdata_pi,
    output logic              stall_po,
    output logic              redirect_valid_po,
    output logic [XLEN_P-1:0] redirect_pc_po
);

    trap_state_e       state_q, state_d;
    trap_state_e       state_eff;
    logic [XLEN_P-1:0] pc_q, pc_d;
    logic [XLEN_P-1:0] cause_q, cause_d;
    logic              mie_q, mie_d;
    logic              take_exc, take_mret, take_irq;
    logic [XLEN_P-1:0] vec_offset;

    // Event arbitration: exception beats MRET beats an enabled interrupt
    always_comb begin
        take_exc  = exc_valid_pi;
        take_mret = !exc_valid_pi && mret_pi;
        take_irq  = !exc_valid_pi && !mret_pi && irq_pi && mie_q;
    end

    // Vectored-mode offset for the external interrupt (4 bytes per cause)
    assign vec_offset = XLEN_P'({IRQ_CAUSE, 2'b00});

    // While reset is held the block looks idle: pure passthrough, no stall
    assign state_eff = reset ? IDLE : state_q;

    // Next-state logic plus the CSR-port mux owned by the current state
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        cause_d           = cause_q;
        write_csr_po      = 1'b0;
        csr_waddr_po      = '0;
        csr_wdata_po      = '0;
        csr_raddr_po      = '0;
        pipe_csr_rdata_po = '0;
        stall_po          = 1'b1;
        redirect_valid_po = 1'b0;
        redirect_pc_po    = '0;

        case (state_eff)
            IDLE: begin
                stall_po          = 1'b0;
                write_csr_po      = pipe_csr_we_pi;
                csr_waddr_po      = pipe_csr_waddr_pi;
                csr_wdata_po      = pipe_csr_wdata_pi;
                csr_raddr_po      = pipe_csr_raddr_pi;
                pipe_csr_rdata_po = csr_rdata_pi;
                if (take_exc) begin
                    pc_d    = trap_pc_pi;
                    cause_d = {1'b0, {(XLEN_P-6){1'b0}}, exc_cause_pi};
                    state_d = T_EPC;
                end else if (take_mret) begin
                    pc_d    = trap_pc_pi;
                    cause_d = '0;
                    state_d = M_STAT;
                end else if (take_irq) begin
                    pc_d    = trap_pc_pi;
                    cause_d = {1'b1, {(XLEN_P-6){1'b0}}, IRQ_CAUSE};
                    state_d = T_EPC;
                end
            end
            T_EPC: begin
                write_csr_po = 1'b1;
                csr_waddr_po = ADDR_MEPC;
                csr_wdata_po = pc_q;
                state_d      = T_CAUSE;
            end
            T_CAUSE: begin
                write_csr_po = 1'b1;
                csr_waddr_po = ADDR_MCAUSE;
                csr_wdata_po = cause_q;
                state_d      = T_STAT;
            end
            T_STAT: begin
                csr_raddr_po               = ADDR_MSTATUS;
                write_csr_po               = 1'b1;
                csr_waddr_po               = ADDR_MSTATUS;
                csr_wdata_po               = csr_rdata_pi;
                csr_wdata_po[MSTATUS_MPIE] = csr_rdata_pi[MSTATUS_MIE];
                csr_wdata_po[MSTATUS_MIE]  = 1'b0;
                state_d                    = T_VEC;
            end
            T_VEC: begin
                csr_raddr_po      = ADDR_MTVEC;
                redirect_valid_po = 1'b1;
                redirect_pc_po    = {csr_rdata_pi[XLEN_P-1:2], 2'b00};
                if (csr_rdata_pi[1:0] == MTVEC_MODE_VECTORED && cause_q[XLEN_P-1]) begin
                    redirect_pc_po = {csr_rdata_pi[XLEN_P-1:2], 2'b00} + vec_offset;
                end
                state_d = IDLE;
            end
            M_STAT: begin
                csr_raddr_po               = ADDR_MSTATUS;
                write_csr_po               = 1'b1;
                csr_waddr_po               = ADDR_MSTATUS;
                csr_wdata_po               = csr_rdata_pi;
                csr_wdata_po[MSTATUS_MIE]  = csr_rdata_pi[MSTATUS_MPIE];
                csr_wdata_po[MSTATUS_MPIE] = 1'b1;
                state_d                    = M_EPC;
            end
            M_EPC: begin
                csr_raddr_po      = ADDR_MEPC;
                redirect_valid_po = 1'b1;
                redirect_pc_po    = {csr_rdata_pi[XLEN_P-1:2], 2'b00};
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow of mstatus.MIE, tracking every write that reaches mstatus
    always_comb begin
        mie_d = mie_q;
        if (write_csr_po && csr_waddr_po == ADDR_MSTATUS) begin
            mie_d = csr_wdata_po[MSTATUS_MIE];
        end
    end

    // State, latched trap PC/cause and MIE shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            mie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mie_q   <= mie_d;
        end
    end

endmodule
